enum_fifo: RTL and testbench
============================

ENUM_FIFO -- requirements
Module: enum_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of entries; power of two, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of each statistics counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer has a value on in_data.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a value this cycle.
REQ-007 SHALL have port in_data  input  8  value of type pkg::enum_t (ONE=0, TWO=1, THREE=2).
REQ-008 SHALL have port out_valid  output  1  head entry present on out_data.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port out_data  output  8  head entry, typed pkg::alias_t.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have port illegal  output  1  sticky flag: an out-of-range code was enqueued.
REQ-013 SHALL have port clr_illegal  input  1  synchronous clear of illegal.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0); both combinational from state.
REQ-016 out_data SHALL be the oldest stored entry (first-word fall-through), driven from storage with no added register stage.
REQ-017 Latency from push into an empty FIFO to out_valid high SHALL be exactly 1 cycle; no same-cycle bypass.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-019 When full, in_ready SHALL be low and in_data ignored even if a pop occurs that cycle.
REQ-020 When empty, out_ready SHALL be ignored and count SHALL not underflow.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 Values are stored unmodified; out_data SHALL equal in_data bit-for-bit, including illegal codes.
REQ-023 A push with in_data > 2 SHALL set illegal on the following edge; illegal SHALL stay high until cleared.
REQ-024 clr_illegal SHALL clear illegal on the next edge; an illegal push in the same cycle SHALL win (illegal stays 1).
REQ-025 count SHALL be recomputed each edge as count + push - pop.

Reset
REQ-026 On rst_n low, immediately and independent of clk: pointers, count, illegal SHALL be 0; in_ready SHALL be 1; out_valid SHALL be 0.
REQ-027 Storage contents SHALL NOT be reset; out_data is don't-care while out_valid is 0.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first push after deassertion SHALL be the first popped.
REQ-029 rst_n deassertion is synchronised externally; the block SHALL not add a synchroniser.

Configuration
REQ-030 Macro ENUM_FIFO_STATS_EN SHALL, when defined, add outputs cnt_one, cnt_two, cnt_three (each CNT_W bits, all in enum_fifo).
REQ-031 With ENUM_FIFO_STATS_EN, each counter SHALL increment on a pop whose out_data equals ONE, TWO or THREE respectively, saturate at 2^CNT_W-1, and reset to 0 on rst_n.
REQ-032 Popped illegal codes SHALL increment no counter.
REQ-033 Without ENUM_FIFO_STATS_EN, the three ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, then push TWO with out_ready=0 -> next cycle out_valid=1, out_data=1, count=1.
REQ-035 DEPTH=4: push ONE,TWO,THREE,ONE, out_ready=0 -> count=4, in_ready=0; fifth push with in_valid=1 ignored; pops return 0,1,2,0.
REQ-036 Full FIFO, in_valid=1 and out_ready=1 together for 1 cycle -> count 4->3, no write; then continuous push/pop for 10 cycles keeps count=3, order preserved across pointer wrap.
REQ-037 Push 8'h05 -> illegal=1 next cycle, popped out_data=8'h05; clr_illegal with simultaneous push 8'h07 -> illegal stays 1; clr_illegal alone -> illegal=0.
REQ-038 Push 3 entries, assert rst_n=0 between edges -> count=0, out_valid=0 immediately; after release push THREE -> first pop returns 2.
REQ-039 ENUM_FIFO_STATS_EN, CNT_W=2: pop ONE five times -> cnt_one=3 (saturated), cnt_two=cnt_three=0.

Source files
------------

// File: rtl/enum_fifo.sv
// Small first-word fall-through FIFO carrying 8-bit enum codes, with a sticky illegal-code flag.
// Defining ENUM_FIFO_STATS_EN adds saturating per-code pop counters (cnt_one/cnt_two/cnt_three).
package pkg;
  typedef enum logic [7:0] {
    ONE   = 8'd0,
    TWO   = 8'd1,
    THREE = 8'd2
  } enum_t;

  // Raw 8-bit view: storage keeps out-of-range codes bit-for-bit.
  typedef logic [7:0] alias_t;
endpackage

module enum_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output pkg::alias_t                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       illegal,
  input  logic                       clr_illegal
`ifdef ENUM_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]           cnt_one,
  output logic [CNT_W-1:0]           cnt_two,
  output logic [CNT_W-1:0]           cnt_three
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("enum_fifo: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          illegal_q, illegal_d;
  logic          push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign illegal   = illegal_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    illegal_d = illegal_q;
    // An illegal push in the same cycle as a clear must keep the flag set.
    if (push && (in_data > 8'(pkg::THREE))) begin
      illegal_d = 1'b1;
    end else if (clr_illegal) begin
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Storage is intentionally not reset; out_data is don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef ENUM_FIFO_STATS_EN
  logic [CNT_W-1:0] cnt_one_q, cnt_one_d;
  logic [CNT_W-1:0] cnt_two_q, cnt_two_d;
  logic [CNT_W-1:0] cnt_three_q, cnt_three_d;

  always_comb begin
    cnt_one_d   = cnt_one_q;
    cnt_two_d   = cnt_two_q;
    cnt_three_d = cnt_three_q;
    if (pop) begin
      if (out_data == 8'(pkg::ONE) && cnt_one_q != '1) begin
        cnt_one_d = cnt_one_q + 1'b1;
      end
      if (out_data == 8'(pkg::TWO) && cnt_two_q != '1) begin
        cnt_two_d = cnt_two_q + 1'b1;
      end
      if (out_data == 8'(pkg::THREE) && cnt_three_q != '1) begin
        cnt_three_d = cnt_three_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_one_q   <= '0;
      cnt_two_q   <= '0;
      cnt_three_q <= '0;
    end else begin
      cnt_one_q   <= cnt_one_d;
      cnt_two_q   <= cnt_two_d;
      cnt_three_q <= cnt_three_d;
    end
  end

  assign cnt_one   = cnt_one_q;
  assign cnt_two   = cnt_two_q;
  assign cnt_three = cnt_three_q;
`endif

endmodule

// File: tb/tb_enum_fifo.sv
// Directed bench for enum_fifo (DEPTH=4): vector table plus hand sequences for
// wrap-around streaming, async reset mid-transfer and, when enabled, the stats counters.
module tb_enum_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  count;
  logic        illegal;
  logic        clr_illegal;
`ifdef ENUM_FIFO_STATS_EN
  logic [1:0]  cnt_one, cnt_two, cnt_three;
`endif

  int n_pass  = 0;
  int n_total = 0;

  enum_fifo #(.DEPTH(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .illegal    (illegal),
    .clr_illegal(clr_illegal)
`ifdef ENUM_FIFO_STATS_EN
    ,
    .cnt_one    (cnt_one),
    .cnt_two    (cnt_two),
    .cnt_three  (cnt_three)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       clr;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
    logic       e_ir;
    logic       e_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy, input logic clr,
                     input logic e_ov, input logic [7:0] e_od, input logic [2:0] e_cnt,
                     input logic e_ir, input logic e_ill);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
    v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ill = e_ill;
    vecs.push_back(v);
  endtask

  // Drive inputs one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    in_valid = iv; in_data = d; out_ready = ordy; clr_illegal = clr;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clr_illegal = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    //   iv  data  ordy clr | ov  od     cnt ir ill
    add(1, 8'd1, 0, 0,  1, 8'd1, 3'd1, 1, 0); // push TWO -> visible next cycle
    add(0, 8'd0, 1, 0,  0, 8'd0, 3'd0, 1, 0);
    add(1, 8'd0, 0, 0,  1, 8'd0, 3'd1, 1, 0); // fill ONE,TWO,THREE,ONE
    add(1, 8'd1, 0, 0,  1, 8'd0, 3'd2, 1, 0);
    add(1, 8'd2, 0, 0,  1, 8'd0, 3'd3, 1, 0);
    add(1, 8'd0, 0, 0,  1, 8'd0, 3'd4, 0, 0);
    add(1, 8'd1, 0, 0,  1, 8'd0, 3'd4, 0, 0); // ignored while full
    add(0, 8'd0, 1, 0,  1, 8'd1, 3'd3, 1, 0); // pops 0,1,2,0
    add(0, 8'd0, 1, 0,  1, 8'd2, 3'd2, 1, 0);
    add(0, 8'd0, 1, 0,  1, 8'd0, 3'd1, 1, 0);
    add(0, 8'd0, 1, 0,  0, 8'd0, 3'd0, 1, 0);
    add(0, 8'd0, 1, 0,  0, 8'd0, 3'd0, 1, 0); // pop on empty: no underflow
    add(1, 8'd2, 1, 0,  1, 8'd2, 3'd1, 1, 0); // no bypass into empty
    add(0, 8'd0, 1, 0,  0, 8'd0, 3'd0, 1, 0);
    add(1, 8'h05, 0, 0, 1, 8'h05, 3'd1, 1, 1); // illegal code stored as-is
    add(0, 8'd0, 1, 0,  0, 8'd0, 3'd0, 1, 1);
    add(1, 8'h07, 0, 1, 1, 8'h07, 3'd1, 1, 1); // illegal push beats clear
    add(0, 8'd0, 1, 1,  0, 8'd0, 3'd0, 1, 0);
    add(1, 8'd2, 0, 0,  1, 8'd2, 3'd1, 1, 0); // refill 2,1,0,2
    add(1, 8'd1, 0, 0,  1, 8'd2, 3'd2, 1, 0);
    add(1, 8'd0, 0, 0,  1, 8'd2, 3'd3, 1, 0);
    add(1, 8'd2, 0, 0,  1, 8'd2, 3'd4, 0, 0);
    add(1, 8'd1, 1, 0,  1, 8'd1, 3'd3, 1, 0); // full: pop only, no write

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].clr);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
      if (vecs[i].e_ov) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
    end

    // Contents now {1,0,2}; stream push+pop for 10 cycles across pointer wrap.
    q = '{8'd1, 8'd0, 8'd2};
    for (int k = 0; k < 10; k++) begin
      logic [7:0] v;
      v = 8'((k + 1) % 3);
      step(1'b1, v, 1'b1, 1'b0);
      void'(q.pop_front());
      q.push_back(v);
      chk($sformatf("stream%0d_count", k), 32'(count), 32'd3);
      chk($sformatf("stream%0d_out_data", k), 32'(out_data), 32'(q[0]));
    end
    while (q.size() > 0) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      void'(q.pop_front());
      chk("drain_count", 32'(count), 32'(q.size()));
      if (q.size() > 0) chk("drain_out_data", 32'(out_data), 32'(q[0]));
    end

    // Reset between edges with three entries stored.
    step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 8'd2, 1'b0, 1'b0);
    chk("post_rst_out_data", 32'(out_data), 32'd2);
    chk("post_rst_count", 32'(count), 32'd1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("post_rst_drain", 32'(count), 32'd0);

`ifdef ENUM_FIFO_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("stats_rst_one", 32'(cnt_one), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'd0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
    end
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("stats_cnt_one_sat", 32'(cnt_one), 32'd3);
    chk("stats_cnt_two", 32'(cnt_two), 32'd1);
    chk("stats_cnt_three", 32'(cnt_three), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
